// File: rtl/homography_pkg.sv
// Shared fixed-point types, constants and saturating arithmetic for the homography mapper.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package homography_pkg;

    localparam int INT_W  = 20;
    localparam int FRAC_W = 13;
    localparam int WIDTH  = INT_W + FRAC_W;

    typedef logic signed [WIDTH-1:0] fix_t;

    localparam fix_t ONE = {{(INT_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
    localparam fix_t MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam fix_t MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {H0, H1, H2, H3, H4, H5, H6, H7} coef_idx_t;

    // Identity transform: h0 = h4 = 1.0, everything else 0.
    function automatic fix_t ident_coef(input int idx);
        return (idx == int'(H0) || idx == int'(H4)) ? ONE : '0;
    endfunction

    function automatic fix_t sat_add(input fix_t a, input fix_t b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        // Two sign bits disagree only on overflow; the carry-out bit gives the true sign.
        if (s[WIDTH] != s[WIDTH-1])
            return s[WIDTH] ? MIN : MAX;
        return s[WIDTH-1:0];
    endfunction

    // Saturating Q x Q multiply.
    function automatic fix_t sat_mul(input fix_t a, input fix_t b);
        logic signed [2*WIDTH-1:0] p;
        p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        p = p >>> FRAC_W;
        if (p[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){p[2*WIDTH-1]}})
            return p[2*WIDTH-1] ? MIN : MAX;
        return p[WIDTH-1:0];
    endfunction

    // Saturating Q / Q divide (truncating). A non-positive divisor returns 0; the
    // caller flags such samples separately so the value is never used.
    function automatic fix_t sat_div(input fix_t n, input fix_t d);
        logic signed [WIDTH+FRAC_W-1:0] num;
        logic signed [WIDTH+FRAC_W-1:0] den;
        logic signed [WIDTH+FRAC_W-1:0] q;
        if (d[WIDTH-1] || d == '0)
            return '0;
        num = {n, {FRAC_W{1'b0}}};
        den = {{FRAC_W{d[WIDTH-1]}}, d};
        q   = num / den;
        if (q[WIDTH+FRAC_W-1:WIDTH-1] != {(FRAC_W+1){q[WIDTH+FRAC_W-1]}})
            return q[WIDTH+FRAC_W-1] ? MIN : MAX;
        return q[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/homography_coef_bank.sv
// Double-buffered coefficient store: shadow bank written by software, active bank used by the datapath.
// Latency: a commit is visible on the active outputs the cycle after the commit edge.
// Backpressure: none; writes and commits are always accepted, even while the pipeline is stalled.
// Ports: clk/rst (sync, active-high); we/addr/data write the shadow bank;
//        commit copies shadow (including a same-cycle write) to active; active[0..7] = h0..h7.
module homography_coef_bank
    import homography_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [2:0] addr,
    input  fix_t       data,
    input  logic       commit,
    output fix_t       active [8]
);

    fix_t shadow     [8];
    fix_t shadow_nxt [8];

    // Shadow including this cycle's write, so a commit in the same cycle picks it up.
    always_comb begin
        shadow_nxt = shadow;
        if (we)
            shadow_nxt[addr] = data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= ident_coef(i);
                active[i] <= ident_coef(i);
            end
        end else begin
            shadow <= shadow_nxt;
            if (commit)
                active <= shadow_nxt;
        end
    end

endmodule

// File: rtl/homography_mapper.sv
// Streaming perspective transform (u,v) = ((h0x+h1y+h2)/D, (h3x+h4y+h5)/D), D = h6x+h7y+1.
// Latency: DIV_LAT+3 cycles from input transfer to o_valid, one sample per cycle.
// Backpressure: the whole pipeline freezes while o_valid & ~i_ready; o_ready equals the advance.
// Ports: i_clk, i_rst (sync, active-high); i_coef_* coefficient shadow write / commit;
//        i_valid/o_ready/i_x/i_y input stream; o_valid/i_ready/o_u/o_v/o_oob output stream.
module homography_mapper
    import homography_pkg::*;
#(
    parameter int X_W     = 11,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int DIV_LAT = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_coef_we,
    input  logic [2:0]     i_coef_addr,
    input  fix_t           i_coef_data,
    input  logic           i_coef_commit,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [X_W-1:0] i_x,
    input  logic [X_W-1:0] i_y,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [X_W-1:0] o_u,
    output logic [X_W-1:0] o_v,
    output logic           o_oob
);

    localparam fix_t           U_LIM = fix_t'(IMG_W);
    localparam fix_t           V_LIM = fix_t'(IMG_H);
    localparam logic [X_W-1:0] U_MAX = X_W'(IMG_W - 1);
    localparam logic [X_W-1:0] V_MAX = X_W'(IMG_H - 1);

    fix_t h [8];
    logic adv;

    assign adv     = ~o_valid | i_ready;
    assign o_ready = adv;

    homography_coef_bank u_coef (
        .clk    (i_clk),
        .rst    (i_rst),
        .we     (i_coef_we),
        .addr   (i_coef_addr),
        .data   (i_coef_data),
        .commit (i_coef_commit),
        .active (h)
    );

    // Integer pixel coordinates as Q values.
    fix_t xq, yq;
    assign xq = {{(WIDTH-X_W-FRAC_W){1'b0}}, i_x, {FRAC_W{1'b0}}};
    assign yq = {{(WIDTH-X_W-FRAC_W){1'b0}}, i_y, {FRAC_W{1'b0}}};

    // S1 products plus the offsets, all taken from one coefficient set.
    fix_t s1_h0x, s1_h1y, s1_h3x, s1_h4y, s1_h6x, s1_h7y, s1_h2, s1_h5;
    // S2 sums
    fix_t s2_nu, s2_nv, s2_den;
    logic s2_bad;
    fix_t den_sum;
    // Divider pipeline (quotients computed from the S2 registers, then delayed)
    fix_t qu_pipe [DIV_LAT];
    fix_t qv_pipe [DIV_LAT];
    logic [DIV_LAT-1:0] bad_pipe;
    // Valid bits, the only pipeline state that needs clearing
    logic s1_vld, s2_vld;
    logic [DIV_LAT-1:0] vld_pipe;

    assign den_sum = sat_add(sat_add(s1_h6x, s1_h7y), ONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_vld   <= 1'b0;
            s2_vld   <= 1'b0;
            vld_pipe <= '0;
        end else if (adv) begin
            s1_vld   <= i_valid;
            s2_vld   <= s1_vld;
            vld_pipe <= {vld_pipe[DIV_LAT-2:0], s2_vld};
        end
    end

    // Datapath registers carry no reset: stale contents are masked by the valid bits.
    always_ff @(posedge i_clk) begin
        if (adv) begin
            s1_h0x <= sat_mul(h[H0], xq);
            s1_h1y <= sat_mul(h[H1], yq);
            s1_h3x <= sat_mul(h[H3], xq);
            s1_h4y <= sat_mul(h[H4], yq);
            s1_h6x <= sat_mul(h[H6], xq);
            s1_h7y <= sat_mul(h[H7], yq);
            s1_h2  <= h[H2];
            s1_h5  <= h[H5];

            s2_nu  <= sat_add(sat_add(s1_h0x, s1_h1y), s1_h2);
            s2_nv  <= sat_add(sat_add(s1_h3x, s1_h4y), s1_h5);
            s2_den <= den_sum;
            s2_bad <= den_sum[WIDTH-1] || (den_sum == '0);

            qu_pipe[0] <= sat_div(s2_nu, s2_den);
            qv_pipe[0] <= sat_div(s2_nv, s2_den);
            for (int i = 1; i < DIV_LAT; i++) begin
                qu_pipe[i] <= qu_pipe[i-1];
                qv_pipe[i] <= qv_pipe[i-1];
            end
            bad_pipe <= {bad_pipe[DIV_LAT-2:0], s2_bad};
        end
    end

    // Final stage: floor to integer, range-check and clamp.
    fix_t qu_int, qv_int;
    logic bad;
    logic [X_W-1:0] u_nxt, v_nxt;
    logic oob_nxt;

    assign qu_int = qu_pipe[DIV_LAT-1] >>> FRAC_W;
    assign qv_int = qv_pipe[DIV_LAT-1] >>> FRAC_W;
    assign bad    = bad_pipe[DIV_LAT-1];

    always_comb begin
        u_nxt   = '0;
        v_nxt   = '0;
        oob_nxt = bad;
        if (!bad) begin
            if (qu_int[WIDTH-1]) begin
                oob_nxt = 1'b1;
            end else if (qu_int >= U_LIM) begin
                u_nxt   = U_MAX;
                oob_nxt = 1'b1;
            end else begin
                u_nxt = qu_int[X_W-1:0];
            end
            if (qv_int[WIDTH-1]) begin
                oob_nxt = 1'b1;
            end else if (qv_int >= V_LIM) begin
                v_nxt   = V_MAX;
                oob_nxt = 1'b1;
            end else begin
                v_nxt = qv_int[X_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_u     <= '0;
            o_v     <= '0;
            o_oob   <= 1'b0;
        end else if (adv) begin
            o_valid <= vld_pipe[DIV_LAT-1];
            o_u     <= u_nxt;
            o_v     <= v_nxt;
            o_oob   <= oob_nxt;
        end
    end

endmodule

// File: tb/tb_homography_mapper.sv
module tb_homography_mapper;
    import homography_pkg::*;

    localparam int X_W     = 11;
    localparam int DIV_LAT = 8;

    logic           clk = 1'b0;
    logic           i_rst = 1'b1;
    logic           i_coef_we = 1'b0;
    logic [2:0]     i_coef_addr = '0;
    fix_t           i_coef_data = '0;
    logic           i_coef_commit = 1'b0;
    logic           i_valid = 1'b0;
    logic           o_ready;
    logic [X_W-1:0] i_x = '0;
    logic [X_W-1:0] i_y = '0;
    logic           o_valid;
    logic           i_ready = 1'b1;
    logic [X_W-1:0] o_u;
    logic [X_W-1:0] o_v;
    logic           o_oob;

    homography_mapper #(
        .X_W(X_W), .IMG_W(640), .IMG_H(480), .DIV_LAT(DIV_LAT)
    ) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr),
        .i_coef_data(i_coef_data), .i_coef_commit(i_coef_commit),
        .i_valid(i_valid), .o_ready(o_ready), .i_x(i_x), .i_y(i_y),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_u(o_u), .o_v(o_v), .o_oob(o_oob)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int nchk = 0;

    // Stimulus/expectation arrays shared by the stream runner.
    int sx [32];
    int sy [32];
    int eu [32];
    int ev [32];
    int eo [32];

    typedef struct {
        bit coef;    // 1: coefficient write, 0: sample
        bit commit;
        int addr;
        int halves;  // coefficient value in units of 0.5
        int x, y, u, v;
        bit oob;
    } vec_t;

    vec_t tbl [$];

    function automatic fix_t fx2(input int halves);
        return fix_t'(halves * 4096);
    endfunction

    function automatic vec_t cv(input int a, input int halves, input bit cm);
        vec_t t;
        t = '{default: 0};
        t.coef = 1'b1; t.addr = a; t.halves = halves; t.commit = cm;
        return t;
    endfunction

    function automatic vec_t sv(input int x, input int y, input int u, input int v, input bit oob);
        vec_t t;
        t = '{default: 0};
        t.x = x; t.y = y; t.u = u; t.v = v; t.oob = oob;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int u, input int v, input int oob);
        nchk++;
        if (int'(o_u) != u || int'(o_v) != v || int'(o_oob) != oob) begin
            errs++;
            $display("FAIL %s: got u=%0d v=%0d oob=%0d, want u=%0d v=%0d oob=%0d",
                     name, o_u, o_v, o_oob, u, v, oob);
        end
    endtask

    task automatic coef_wr(input int addr, input fix_t data, input bit cm);
        i_coef_we     = 1'b1;
        i_coef_addr   = 3'(addr);
        i_coef_data   = data;
        i_coef_commit = cm;
        tick();
        i_coef_we     = 1'b0;
        i_coef_commit = 1'b0;
    endtask

    // Streams n samples from sx/sy, checks every valid output cycle against the
    // front of eu/ev/eo (so a stalled output must hold its value), optionally
    // stalls i_ready and inserts a commit before sample index commit_at.
    task automatic run_stream(input string tag, input int n, input int st_s, input int st_l,
                              input int commit_at, output int lat);
        int sent, got, cyc, t_in, t_out, extra;
        bit committed;
        sent = 0; got = 0; cyc = 0; t_in = -1; t_out = -1; committed = 1'b0;
        while (got < n && cyc < 300) begin
            i_coef_commit = 1'b0;
            if (sent == commit_at && !committed) begin
                i_valid = 1'b0;
                i_coef_commit = 1'b1;
                committed = 1'b1;
            end else if (sent < n) begin
                i_valid = 1'b1;
                i_x = X_W'(sx[sent]);
                i_y = X_W'(sy[sent]);
            end else begin
                i_valid = 1'b0;
            end
            i_ready = !(cyc >= st_s && cyc < st_s + st_l);
            #1;
            if (o_valid) begin
                if (t_out < 0) t_out = cyc;
                check_out($sformatf("%s[%0d]", tag, got), eu[got], ev[got], eo[got]);
                if (i_ready) got++;
            end
            if (i_valid && o_ready) begin
                if (t_in < 0) t_in = cyc;
                sent++;
            end
            tick();
            cyc++;
        end
        i_valid = 1'b0;
        i_coef_commit = 1'b0;
        i_ready = 1'b1;
        check_int({tag, "_delivered"}, got, n);
        extra = 0;
        for (int i = 0; i < DIV_LAT + 4; i++) begin
            if (o_valid) extra++;
            tick();
        end
        check_int({tag, "_extra"}, extra, 0);
        lat = t_out - t_in;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int lat;
        int vcnt;

        // Reset
        repeat (3) tick();
        i_rst = 1'b0;
        check_int("rst_o_valid", int'(o_valid), 0);
        check_int("rst_o_ready", int'(o_ready), 1);
        check_out("rst_outputs", 0, 0, 0);

        // Identity after reset, with first-output latency
        sx[0] = 0;   sy[0] = 0;   eu[0] = 0;   ev[0] = 0;   eo[0] = 0;
        sx[1] = 5;   sy[1] = 7;   eu[1] = 5;   ev[1] = 7;   eo[1] = 0;
        sx[2] = 639; sy[2] = 479; eu[2] = 639; ev[2] = 479; eo[2] = 0;
        run_stream("identity", 3, -1, 0, -1, lat);
        check_int("latency", lat, DIV_LAT + 3);

        // Directed vectors; H4 write shares its cycle with the commit (bypass)
        tbl.push_back(cv(0, 4, 0));             // h0 = 2.0 (shadow)
        tbl.push_back(cv(4, 1, 1));             // h4 = 0.5, commit
        tbl.push_back(sv(100, 100, 200, 50, 0));
        tbl.push_back(cv(0, 14, 0));            // h0 = 7.0, not committed
        tbl.push_back(sv(10, 10, 20, 5, 0));
        tbl.push_back(cv(0, 2, 0));             // h0 = 1.0
        tbl.push_back(cv(4, 2, 0));             // h4 = 1.0
        tbl.push_back(cv(2, -20, 1));           // h2 = -10.0, commit
        tbl.push_back(sv(3, 20, 0, 20, 1));
        tbl.push_back(sv(15, 20, 5, 20, 0));
        tbl.push_back(sv(660, 20, 639, 20, 1));
        tbl.push_back(sv(15, 500, 5, 479, 1));
        tbl.push_back(cv(2, 0, 0));             // h2 = 0
        tbl.push_back(cv(6, -2, 1));            // h6 = -1.0, commit
        tbl.push_back(sv(1, 0, 0, 0, 1));       // D = 0
        tbl.push_back(sv(0, 4, 0, 4, 0));       // D = 1.0
        tbl.push_back(sv(2, 0, 0, 0, 1));       // D = -1.0
        tbl.push_back(cv(6, 2, 1));             // h6 = 1.0, commit
        tbl.push_back(sv(3, 10, 0, 2, 0));      // D = 4: 0.75, 2.5
        tbl.push_back(sv(7, 500, 0, 62, 0));    // D = 8: 0.875, 62.5

        for (int k = 0; k < tbl.size(); k++) begin
            if (tbl[k].coef) begin
                coef_wr(tbl[k].addr, fx2(tbl[k].halves), tbl[k].commit);
            end else begin
                sx[0] = tbl[k].x; sy[0] = tbl[k].y;
                eu[0] = tbl[k].u; ev[0] = tbl[k].v; eo[0] = int'(tbl[k].oob);
                run_stream($sformatf("vec%0d", k), 1, -1, 0, -1, lat);
            end
        end

        // Mid-stream commit: h6 back to 0, then h0 = 2.0 staged and committed between samples 1 and 2
        coef_wr(6, '0, 1'b1);
        coef_wr(0, fx2(4), 1'b0);
        for (int i = 0; i < 4; i++) begin
            sx[i] = 10 + i; sy[i] = 1;
            eu[i] = (i < 2) ? (10 + i) : 2 * (10 + i);
            ev[i] = 1; eo[i] = 0;
        end
        run_stream("commit", 4, -1, 0, 2, lat);

        // Backpressure: 20 samples, i_ready low 5 cycles while outputs are flowing
        for (int i = 0; i < 20; i++) begin
            sx[i] = i; sy[i] = i; eu[i] = 2 * i; ev[i] = i; eo[i] = 0;
        end
        run_stream("stall", 20, 13, 5, -1, lat);

        // Reset with the pipeline full
        i_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            i_valid = 1'b1; i_x = X_W'(i); i_y = '0;
            tick();
        end
        i_valid = 1'b0;
        check_int("pre_rst_valid", int'(o_valid), 1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check_int("post_rst_valid", int'(o_valid), 0);
        check_out("post_rst_outputs", 0, 0, 0);
        vcnt = 0;
        for (int i = 0; i < DIV_LAT + 6; i++) begin
            if (o_valid) vcnt++;
            tick();
        end
        check_int("post_rst_flush", vcnt, 0);
        sx[0] = 5; sy[0] = 7; eu[0] = 5; ev[0] = 7; eo[0] = 0;
        run_stream("post_rst_identity", 1, -1, 0, -1, lat);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
